// File: rtl/maxpool_relu_32_2_16.sv
// ============================================================================
//  Module      : maxpool_relu_32_2_16
//  Description : Streaming 1-D max-pooling stage. Incoming samples are grouped
//                into non-overlapping windows of P samples and each window
//                emits its signed maximum. Optional ReLU applied after pooling.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous, active-low reset
//                x_data   - signed input sample (T bits)
//                x_valid  - upstream offers x_data
//                x_ready  - block accepts x_data this cycle
//                y_data   - signed pooled result (T bits)
//                y_valid  - y_data holds a result
//                y_ready  - downstream accepts y_data this cycle
//  Config      : define POOL_RELU_EN to clamp negative pooled results to 0;
//                when undefined the signed max is passed through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_relu_32_2_16 #(
    parameter int T = 16,
    parameter int N = 32,
    parameter int P = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready
);

    localparam int C_NW = N / P;
    localparam int C_SW = (P > 1) ? $clog2(P) : 1;
    localparam int C_WW = (C_NW > 1) ? $clog2(C_NW) : 1;

    localparam logic [C_SW-1:0] C_S_LAST = C_SW'(P - 1);
    localparam logic [C_WW-1:0] C_W_LAST = C_WW'(C_NW - 1);

    logic [C_SW-1:0]        r_s;
    logic [C_WW-1:0]        r_w;
    logic signed [T-1:0]    r_run;
    logic signed [T-1:0]    r_y_data;
    logic                   r_y_valid;

    logic                   w_last;
    logic                   w_x_fire;
    logic                   w_y_fire;
    logic signed [T-1:0]    w_max;
    logic signed [T-1:0]    w_act;

    assign w_last   = (r_s == C_S_LAST);
    // Only stall the last sample of a window, and only when the single-entry
    // output register is occupied and not draining this cycle.
    assign x_ready  = !(w_last && r_y_valid && !y_ready);
    assign w_x_fire = x_valid && x_ready;
    assign w_y_fire = r_y_valid && y_ready;

    assign y_data   = r_y_data;
    assign y_valid  = r_y_valid;

    always_comb begin
        w_max = (x_data > r_run) ? x_data : r_run;
        w_act = w_max;
`ifdef POOL_RELU_EN
        if (w_max[T-1]) begin
            w_act = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s       <= '0;
            r_w       <= '0;
            r_run     <= '0;
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
        end else begin
            if (w_x_fire) begin
                if (w_last) begin
                    r_s      <= '0;
                    r_w      <= (r_w == C_W_LAST) ? '0 : r_w + C_WW'(1);
                    r_y_data <= w_act;
                end else begin
                    r_s   <= r_s + C_SW'(1);
                    r_run <= (r_s == '0) ? x_data : w_max;
                end
            end

            // A new result overrides the clear so back-to-back windows
            // stream without a bubble even while the old result drains.
            if (w_x_fire && w_last) begin
                r_y_valid <= 1'b1;
            end else if (w_y_fire) begin
                r_y_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_relu_32_2_16.sv
`default_nettype none

module tb_maxpool_relu_32_2_16;

    localparam int T = 16;
    localparam int N = 32;
    localparam int P = 2;
`ifdef POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [T-1:0] x_data;
    logic         x_valid;
    logic         x_ready;
    logic [T-1:0] y_data;
    logic         y_valid;
    logic         y_ready;

    int total = 0;
    int bad   = 0;

    maxpool_relu_32_2_16 #(.T(T), .N(N), .P(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: collects accepted samples into windows, computes the
    // signed max (optionally ReLU'd) and checks outputs in order.
    // ------------------------------------------------------------------
    int           win[$];
    logic [T-1:0] expq[$];
    bit           pv_hold;
    logic [T-1:0] pv_data;
    int           n_out;

    always @(negedge clk) begin
        int mx;
        if (!reset) begin
            win.delete();
            expq.delete();
            pv_hold = 1'b0;
        end else begin
            if (pv_hold) begin
                chk("hold_valid", 32'(y_valid), 32'd1);
                chk("hold_data", 32'(y_data), 32'(pv_data));
            end
            chk("x_ready_rule", 32'(x_ready),
                32'(!(win.size() == P - 1 && y_valid && !y_ready)));
            if (y_valid && y_ready) begin
                n_out++;
                if (expq.size() == 0) chk("unexpected_out", 32'(y_data), 32'hDEAD_BEEF);
                else                  chk("out_data", 32'(y_data), 32'(expq.pop_front()));
            end
            if (x_valid && x_ready) begin
                win.push_back(int'($signed(x_data)));
                if (win.size() == P) begin
                    mx = win[0];
                    foreach (win[k]) if (win[k] > mx) mx = win[k];
                    if (RELU && mx < 0) mx = 0;
                    expq.push_back(mx[T-1:0]);
                    win.delete();
                end
            end
            pv_hold = y_valid && !y_ready;
            pv_data = y_data;
        end
    end

    // Present one sample for exactly one edge (caller guarantees x_ready).
    task automatic send(input logic [T-1:0] v);
        x_valid = 1'b1;
        x_data  = v;
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic do_reset();
        x_valid = 1'b0;
        reset   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
    endtask

    typedef struct {
        logic [T-1:0] a;
        logic [T-1:0] b;
        logic [T-1:0] raw;
        logic [T-1:0] rl;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int i, cyc, r;
        bit acc;

        tbl[0] = '{16'h0005, 16'hFFFD, 16'h0005, 16'h0005};
        tbl[1] = '{16'h0007, 16'h0009, 16'h0009, 16'h0009};
        tbl[2] = '{16'hFFF8, 16'hFFFE, 16'hFFFE, 16'h0000};
        tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000};
        tbl[4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
        tbl[5] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[6] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        tbl[8] = '{16'h1234, 16'h0ABC, 16'h1234, 16'h1234};

        reset = 1'b0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0; n_out = 0;
        @(posedge clk); #2;
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_x_ready", 32'(x_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Streaming table: one result visible the cycle after each window.
        y_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            send(tbl[k].a);
            chk("tbl_mid_valid", 32'(y_valid), 32'd0);
            chk("tbl_x_ready", 32'(x_ready), 32'd1);
            send(tbl[k].b);
            chk("tbl_valid", 32'(y_valid), 32'd1);
            chk("tbl_data", 32'(y_data), 32'(RELU ? tbl[k].rl : tbl[k].raw));
        end

        // Backpressure: result 2 held, sample 4 stalled, then both drain.
        do_reset();
        y_ready = 1'b0;
        send(16'd1);
        send(16'd2);
        chk("bp_valid", 32'(y_valid), 32'd1);
        chk("bp_data", 32'(y_data), 32'd2);
        send(16'd3);
        x_valid = 1'b1; x_data = 16'd4; #1;
        chk("bp_stall", 32'(x_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_hold_data", 32'(y_data), 32'd2);
        chk("bp_stall2", 32'(x_ready), 32'd0);
        y_ready = 1'b1; #1;
        chk("bp_release", 32'(x_ready), 32'd1);
        @(posedge clk); #1;
        x_valid = 1'b0;
        chk("bp_nobubble", 32'(y_valid), 32'd1);
        chk("bp_data4", 32'(y_data), 32'd4);
        @(posedge clk); #1;
        chk("bp_clear", 32'(y_valid), 32'd0);

        // Reset with a pending output and a partial window.
        y_ready = 1'b0;
        send(16'd10);
        send(16'd20);
        send(16'd30);
        chk("rs_pending", 32'(y_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rs_y_valid", 32'(y_valid), 32'd0);
        chk("rs_y_data", 32'(y_data), 32'd0);
        chk("rs_x_ready", 32'(x_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        y_ready = 1'b1;
        send(16'd6);
        send(16'd1);
        chk("rs_after_valid", 32'(y_valid), 32'd1);
        chk("rs_after_data", 32'(y_data), 32'd6);

        // Random handshakes over 104 full vectors.
        do_reset();
        n_out = 0; cyc = 0; i = 0;
        while (i < 104 * N && cyc < 40000) begin
            x_valid = 1'($urandom_range(0, 1));
            y_ready = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 15));
            x_data = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7FFF : 16'($urandom);
            #1;
            acc = x_valid && x_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        chk("rand_budget", 32'(i), 32'(104 * N));
        x_valid = 1'b0;
        y_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_outputs", 32'(n_out), 32'(104 * N / P));
        chk("rand_drained", 32'(expq.size()), 32'd0);

        // Full throughput: one sample per cycle for a whole vector.
        n_out = 0;
        for (int k = 0; k < N; k++) begin
            x_valid = 1'b1;
            y_ready = 1'b1;
            x_data  = 16'($urandom);
            #1;
            chk("ft_x_ready", 32'(x_ready), 32'd1);
            @(posedge clk); #1;
            if (k % P == P - 1) chk("ft_valid", 32'(y_valid), 32'd1);
        end
        x_valid = 1'b0;
        @(posedge clk); #1;
        chk("ft_outputs", 32'(n_out), 32'(N / P));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
